matmul_tile_sequencer: RTL and testbench
========================================

Name: matmul_tile_sequencer

Overview:
- Parametrised job-level controller above the systolic-array master control.
- Splits an arbitrary (M x K) * (K x N) matmul, expressed in WIDTH_HEIGHT-sized tiles, into a stream of per-tile commands: weight load, matmul with accumulate/clear, and accum-table drain through ReLU to output memory.
- Uses output-stationary loop order, a valid/ready command handshake, and one command outstanding at a time.

Parameters:
- WIDTH_HEIGHT, 16, systolic array rows/cols (tile edge).
- MAX_MAT_DIM, 128, maximum matrix dimension in elements.
- TILE_IDX_W, $clog2(MAX_MAT_DIM/WIDTH_HEIGHT) = 3, width of a tile index.
- CNT_W, TILE_IDX_W+1 = 4, width of tile-count inputs (range 1..MAX_MAT_DIM/WIDTH_HEIGHT).

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- job_start, input, 1, single-cycle job request.
- job_m_tiles, input, CNT_W, output tile rows M_t.
- job_k_tiles, input, CNT_W, reduction tiles K_t.
- job_n_tiles, input, CNT_W, output tile cols N_t.
- job_relu, input, 1, apply ReLU on drain.
- job_busy, output, 1, job in progress.
- job_done, output, 1, one-cycle pulse when the job completes.
- job_err, output, 1, one-cycle pulse when a job is rejected.
- cmd_valid, output, 1, command valid.
- cmd_ready, input, 1, engine accepts the command.
- cmd_opcode, output, 3, 3'd1 LOAD_W, 3'd2 MATMUL, 3'd3 DRAIN.
- cmd_row, output, TILE_IDX_W, output submatrix row r.
- cmd_col, output, TILE_IDX_W, output submatrix col c.
- cmd_k, output, TILE_IDX_W, reduction tile k.
- cmd_accum, output, 1, MATMUL: 1 = add to accum table, 0 = overwrite.
- cmd_relu, output, 1, DRAIN: ReLU enable (latched job_relu).
- cmd_done, input, 1, engine pulse when the accepted command has finished.
- tiles_done, output, 2*CNT_W, count of output tiles drained in the current job.

Behaviour:
- All outputs registered. All outputs are 0 in reset and in IDLE; tiles_done holds its value after a job until the next accepted start.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - job_start with any count equal to 0 or greater than MAX_MAT_DIM/WIDTH_HEIGHT: job_err pulses next cycle, no commands issued, remain IDLE.
  - Valid job_start: latch the counts and job_relu, clear r/c/k/phase/tiles_done, set job_busy, go to ISSUE. cmd_valid is high the cycle after job_start.
- ISSUE: cmd_valid=1 and the cmd_* fields are held stable until cmd_valid&&cmd_ready, then go to WAIT with cmd_valid=0 the next cycle.
- WAIT: cmd_done advances the sequence. The next command's cmd_valid rises the cycle after cmd_done. cmd_done outside WAIT is ignored, including in the handshake cycle itself.
- Command sequence per output tile (r,c):
  - For k = 0..K_t-1: LOAD_W(r,c,k), then MATMUL(r,c,k) with cmd_accum = (k != 0).
  - Then DRAIN(r,c), with cmd_k = 0 and cmd_relu = latched relu.
  - Field values on non-applicable opcodes: cmd_accum = 0 except on MATMUL; cmd_relu = 0 except on DRAIN.
- tiles_done increments on the cmd_done of each DRAIN.
- Tile advance: c increments first; on c wrapping at N_t-1, c returns to 0 and r increments.
- After the DRAIN of (M_t-1, N_t-1) completes, go to FINISH. FINISH is one cycle: job_done=1, job_busy=0, then IDLE.
- Total commands per job = M_t*N_t*(2*K_t+1).
- job_start while job_busy is ignored and latched values are unchanged.
- Reset mid-job: next cycle is IDLE with all outputs 0 and any in-flight command abandoned. The engine-side reset is a separate signal outside this block.
- cmd_ready held high continuously: one command per handshake, with no double issue.

Test Plan:
- M=K=N=1, relu=1, cmd_ready=1, cmd_done 3 cycles after each handshake -> commands LOAD_W(0,0,0), MATMUL(0,0,0,accum=0), DRAIN(0,0,relu=1); job_done pulses once; tiles_done=1.
- M=2,K=3,N=2 -> 28 commands; on tile (0,0) the MATMUL accum flags are 0,1,1; tile order is (0,0),(0,1),(1,0),(1,1); tiles_done=4 at done.
- M=K=N=8 with cmd_ready toggling randomly -> exactly 1088 handshakes; cmd_* fields stable while valid&&!ready; final DRAIN is (7,7).
- job_n_tiles=0 or 9 -> job_err pulse; cmd_valid stays 0; job_busy stays 0.
- Spurious cmd_done in ISSUE and a second job_start while busy -> both ignored; command sequence identical to the reference run.
- reset asserted during WAIT of the 5th command -> next cycle IDLE with all outputs 0; a new job after reset runs from (0,0,0).

Source files
------------

// File: rtl/matmul_tile_sequencer.sv
// Job-level tile sequencer: walks an output-stationary (r, c, k) loop over a tiled matmul
// and hands LOAD_W / MATMUL / DRAIN commands to the array engine one at a time.
module matmul_tile_sequencer #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int MAX_MAT_DIM  = 128,
  parameter int TILE_IDX_W   = $clog2(MAX_MAT_DIM / WIDTH_HEIGHT),
  parameter int CNT_W        = TILE_IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_start,
  input  logic [CNT_W-1:0]      job_m_tiles,
  input  logic [CNT_W-1:0]      job_k_tiles,
  input  logic [CNT_W-1:0]      job_n_tiles,
  input  logic                  job_relu,
  output logic                  job_busy,
  output logic                  job_done,
  output logic                  job_err,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [2:0]            cmd_opcode,
  output logic [TILE_IDX_W-1:0] cmd_row,
  output logic [TILE_IDX_W-1:0] cmd_col,
  output logic [TILE_IDX_W-1:0] cmd_k,
  output logic                  cmd_accum,
  output logic                  cmd_relu,
  input  logic                  cmd_done,
  output logic [2*CNT_W-1:0]    tiles_done
);

  localparam logic [CNT_W-1:0]      MAX_TILES = CNT_W'(MAX_MAT_DIM / WIDTH_HEIGHT);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [TILE_IDX_W-1:0] IDX_ONE   = TILE_IDX_W'(1);
  localparam logic [2*CNT_W-1:0]    TILE_ONE  = (2*CNT_W)'(1);

  localparam logic [2:0] OP_LOAD_W = 3'd1;
  localparam logic [2:0] OP_MATMUL = 3'd2;
  localparam logic [2:0] OP_DRAIN  = 3'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;
  typedef enum logic [1:0] {PH_LOAD, PH_MATMUL, PH_DRAIN} phase_t;

  state_t                state, state_n;
  phase_t                phase, phase_n;
  logic [CNT_W-1:0]      m_tiles, m_tiles_n;
  logic [CNT_W-1:0]      k_tiles, k_tiles_n;
  logic [CNT_W-1:0]      n_tiles, n_tiles_n;
  logic                  relu_q, relu_q_n;
  logic [TILE_IDX_W-1:0] r, r_n, c, c_n, k, k_n;
  logic [2*CNT_W-1:0]    tiles_done_n;
  logic                  job_busy_n, job_done_n, job_err_n, cmd_valid_n;
  logic [2:0]            cmd_opcode_n;
  logic [TILE_IDX_W-1:0] cmd_row_n, cmd_col_n, cmd_k_n;
  logic                  cmd_accum_n, cmd_relu_n;
  logic                  bad_job, last_k, last_c, last_r;

  assign bad_job = (job_m_tiles == '0) || (job_m_tiles > MAX_TILES) ||
                   (job_k_tiles == '0) || (job_k_tiles > MAX_TILES) ||
                   (job_n_tiles == '0) || (job_n_tiles > MAX_TILES);
  assign last_k  = (CNT_W'(k) == k_tiles - CNT_ONE);
  assign last_c  = (CNT_W'(c) == n_tiles - CNT_ONE);
  assign last_r  = (CNT_W'(r) == m_tiles - CNT_ONE);

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    m_tiles_n    = m_tiles;
    k_tiles_n    = k_tiles;
    n_tiles_n    = n_tiles;
    relu_q_n     = relu_q;
    r_n          = r;
    c_n          = c;
    k_n          = k;
    tiles_done_n = tiles_done;
    job_err_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (job_start) begin
          if (bad_job) begin
            job_err_n = 1'b1;
          end else begin
            m_tiles_n    = job_m_tiles;
            k_tiles_n    = job_k_tiles;
            n_tiles_n    = job_n_tiles;
            relu_q_n     = job_relu;
            r_n          = '0;
            c_n          = '0;
            k_n          = '0;
            phase_n      = PH_LOAD;
            tiles_done_n = '0;
            state_n      = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cmd_valid && cmd_ready) state_n = WAIT;
      end
      WAIT: begin
        if (cmd_done) begin
          state_n = ISSUE;
          unique case (phase)
            PH_LOAD:   phase_n = PH_MATMUL;
            PH_MATMUL: begin
              if (last_k) begin
                phase_n = PH_DRAIN;
              end else begin
                k_n     = k + IDX_ONE;
                phase_n = PH_LOAD;
              end
            end
            PH_DRAIN: begin
              // Column advances first; the final DRAIN ends the job instead of issuing.
              tiles_done_n = tiles_done + TILE_ONE;
              k_n          = '0;
              phase_n      = PH_LOAD;
              if (last_c) begin
                c_n = '0;
                if (last_r) state_n = FINISH;
                else        r_n = r + IDX_ONE;
              end else begin
                c_n = c + IDX_ONE;
              end
            end
            default: phase_n = PH_LOAD;
          endcase
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    job_busy_n   = (state_n == ISSUE) || (state_n == WAIT);
    job_done_n   = (state_n == FINISH);
    cmd_valid_n  = (state_n == ISSUE);
    cmd_opcode_n = '0;
    cmd_row_n    = '0;
    cmd_col_n    = '0;
    cmd_k_n      = '0;
    cmd_accum_n  = 1'b0;
    cmd_relu_n   = 1'b0;
    // Fields are rebuilt from the loop position while issuing and frozen while waiting.
    if (state_n == ISSUE) begin
      cmd_row_n = r_n;
      cmd_col_n = c_n;
      unique case (phase_n)
        PH_LOAD: begin
          cmd_opcode_n = OP_LOAD_W;
          cmd_k_n      = k_n;
        end
        PH_MATMUL: begin
          cmd_opcode_n = OP_MATMUL;
          cmd_k_n      = k_n;
          cmd_accum_n  = (k_n != '0);
        end
        PH_DRAIN: begin
          cmd_opcode_n = OP_DRAIN;
          cmd_relu_n   = relu_q_n;
        end
        default: cmd_opcode_n = '0;
      endcase
    end else if (state_n == WAIT) begin
      cmd_opcode_n = cmd_opcode;
      cmd_row_n    = cmd_row;
      cmd_col_n    = cmd_col;
      cmd_k_n      = cmd_k;
      cmd_accum_n  = cmd_accum;
      cmd_relu_n   = cmd_relu;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= PH_LOAD;
      m_tiles    <= '0;
      k_tiles    <= '0;
      n_tiles    <= '0;
      relu_q     <= 1'b0;
      r          <= '0;
      c          <= '0;
      k          <= '0;
      tiles_done <= '0;
      job_busy   <= 1'b0;
      job_done   <= 1'b0;
      job_err    <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_opcode <= '0;
      cmd_row    <= '0;
      cmd_col    <= '0;
      cmd_k      <= '0;
      cmd_accum  <= 1'b0;
      cmd_relu   <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      m_tiles    <= m_tiles_n;
      k_tiles    <= k_tiles_n;
      n_tiles    <= n_tiles_n;
      relu_q     <= relu_q_n;
      r          <= r_n;
      c          <= c_n;
      k          <= k_n;
      tiles_done <= tiles_done_n;
      job_busy   <= job_busy_n;
      job_done   <= job_done_n;
      job_err    <= job_err_n;
      cmd_valid  <= cmd_valid_n;
      cmd_opcode <= cmd_opcode_n;
      cmd_row    <= cmd_row_n;
      cmd_col    <= cmd_col_n;
      cmd_k      <= cmd_k_n;
      cmd_accum  <= cmd_accum_n;
      cmd_relu   <= cmd_relu_n;
    end
  end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Bench for matmul_tile_sequencer: a nested-loop command model plus an engine that
// answers each accepted command with cmd_done after a programmable delay.
module tb_matmul_tile_sequencer;

  localparam int TIW = 3;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           job_start;
  logic [CW-1:0]  job_m_tiles, job_k_tiles, job_n_tiles;
  logic           job_relu;
  logic           job_busy, job_done, job_err;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_opcode;
  logic [TIW-1:0] cmd_row, cmd_col, cmd_k;
  logic           cmd_accum, cmd_relu;
  logic           cmd_done;
  logic [2*CW-1:0] tiles_done;

  matmul_tile_sequencer dut (
    .clk(clk), .reset(reset), .job_start(job_start),
    .job_m_tiles(job_m_tiles), .job_k_tiles(job_k_tiles), .job_n_tiles(job_n_tiles),
    .job_relu(job_relu), .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_k(cmd_k), .cmd_accum(cmd_accum),
    .cmd_relu(cmd_relu), .cmd_done(cmd_done), .tiles_done(tiles_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] k;
    logic       accum;
    logic       relu;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t log_q[$];
  int   checks = 0;
  int   failures = 0;
  int   hs_count = 0;
  int   done_pulses = 0;
  int   done_delay = 3;
  bit   rand_ready = 1'b0;
  bit   spurious = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input int op, input int r, input int c, input int k,
                              input int a, input int rl);
    cmd_t t;
    t.op = 3'(op); t.row = 3'(r); t.col = 3'(c); t.k = 3'(k);
    t.accum = 1'(a); t.relu = 1'(rl);
    return t;
  endfunction

  // Output-stationary reference order: every (r,c) gets K_t load/matmul pairs, then a drain.
  task automatic buildModel(input int m, input int kt, input int n, input bit relu);
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        for (int kk = 0; kk < kt; kk++) begin
          exp_q.push_back(mk(1, r, c, kk, 0, 0));
          exp_q.push_back(mk(2, r, c, kk, (kk != 0) ? 1 : 0, 0));
        end
        exp_q.push_back(mk(3, r, c, 0, 0, relu));
      end
  endtask

  task automatic checkIdle(input string tag, input logic [2*CW-1:0] exp_tiles);
    checkOutput({tag, "_outputs_zero"},
                32'({job_busy, job_done, job_err, cmd_valid, cmd_opcode, cmd_row, cmd_col,
                     cmd_k, cmd_accum, cmd_relu}), 32'd0);
    checkOutput({tag, "_tiles_done"}, 32'(tiles_done), 32'(exp_tiles));
  endtask

  task automatic applyStimulus(input int m, input int kt, input int n, input bit relu,
                               input bit accept);
    @(negedge clk);
    if (accept) buildModel(m, kt, n, relu);
    job_m_tiles = CW'(m);
    job_k_tiles = CW'(kt);
    job_n_tiles = CW'(n);
    job_relu    = relu;
    job_start   = 1'b1;
    @(negedge clk);
    job_start   = 1'b0;
  endtask

  task automatic runJob(input int m, input int kt, input int n, input bit relu,
                        input bit inject, output int hs_delta);
    int d0, h0, i;
    log_q.delete();
    d0 = done_pulses;
    h0 = hs_count;
    applyStimulus(m, kt, n, relu, 1'b1);
    checkOutput("valid_after_start", 32'(cmd_valid), 32'd1);
    checkOutput("busy_after_start", 32'(job_busy), 32'd1);
    if (inject) begin
      repeat (10) @(negedge clk);
      applyStimulus(1, 1, 1, ~relu, 1'b0);
    end
    for (i = 0; i < 20000 && done_pulses == d0; i++) @(negedge clk);
    if (done_pulses == d0) checkOutput("job_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("done_pulse_count", 32'(done_pulses - d0), 32'd1);
    checkOutput("model_drained", 32'(exp_q.size()), 32'd0);
    checkIdle("post_job", (2*CW)'(m * n));
    hs_delta = hs_count - h0;
  endtask

  // Engine + compare process: acknowledges commands and checks every accepted command.
  initial begin : engine
    int   cnt;
    bit   rdy;
    bit   prev_stall;
    cmd_t prev_cmd, cur, e;
    cnt = 0;
    prev_stall = 1'b0;
    prev_cmd = '0;
    cmd_ready = 1'b0;
    cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
        cmd_done = 1'b0;
        cmd_ready = 1'b1;
        prev_stall = 1'b0;
      end else begin
        cur.op = cmd_opcode; cur.row = cmd_row; cur.col = cmd_col;
        cur.k = cmd_k; cur.accum = cmd_accum; cur.relu = cmd_relu;
        if (prev_stall && cmd_valid) checkOutput("fields_stable", 32'(cur), 32'(prev_cmd));
        if (cmd_valid) checkOutput("busy_with_valid", 32'(job_busy), 32'd1);
        if (job_done) begin
          done_pulses++;
          checkOutput("busy_low_on_done", 32'(job_busy), 32'd0);
        end
        cmd_done = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) cmd_done = 1'b1;
        end
        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (spurious && cmd_valid) cmd_done = 1'b1;
        cmd_ready = rdy;
        prev_stall = cmd_valid && !rdy;
        prev_cmd = cur;
        if (cmd_valid && rdy) begin
          hs_count++;
          log_q.push_back(cur);
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_cmd", 32'(cur), 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("cmd_fields", 32'(cur), 32'(e));
          end
          cnt = done_delay;
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    int hs, i, h0;
    reset = 1'b1;
    job_start = 1'b0;
    job_m_tiles = '0; job_k_tiles = '0; job_n_tiles = '0;
    job_relu = 1'b0;
    repeat (3) @(negedge clk);
    checkIdle("reset", '0);
    reset = 1'b0;

    // 1x1x1 with relu, done 3 cycles after each handshake
    done_delay = 3;
    runJob(1, 1, 1, 1'b1, 1'b0, hs);
    checkOutput("t1_handshakes", 32'(hs), 32'd3);
    checkOutput("t1_cmd0", 32'(log_q[0]), 32'(cmd_t'({3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0})));
    checkOutput("t1_cmd1", 32'(log_q[1]), 32'(cmd_t'({3'd2, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0})));
    checkOutput("t1_cmd2", 32'(log_q[2]), 32'(cmd_t'({3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1})));
    checkOutput("t1_tiles_done", 32'(tiles_done), 32'd1);

    // 2x3x2: 28 commands, accum pattern and tile order
    done_delay = 2;
    runJob(2, 3, 2, 1'b0, 1'b0, hs);
    checkOutput("t2_handshakes", 32'(hs), 32'd28);
    checkOutput("t2_accum_k0", 32'(log_q[1].accum), 32'd0);
    checkOutput("t2_accum_k1", 32'(log_q[3].accum), 32'd1);
    checkOutput("t2_accum_k2", 32'(log_q[5].accum), 32'd1);
    checkOutput("t2_drain_00", 32'({log_q[6].op, log_q[6].row, log_q[6].col}), 32'h0C0);
    checkOutput("t2_drain_01", 32'({log_q[13].op, log_q[13].row, log_q[13].col}), 32'h0C1);
    checkOutput("t2_drain_10", 32'({log_q[20].op, log_q[20].row, log_q[20].col}), 32'h0C8);
    checkOutput("t2_drain_11", 32'({log_q[27].op, log_q[27].row, log_q[27].col}), 32'h0C9);
    checkOutput("t2_tiles_done", 32'(tiles_done), 32'd4);

    // 8x8x8 with random backpressure
    done_delay = 1;
    rand_ready = 1'b1;
    runJob(8, 8, 8, 1'b1, 1'b0, hs);
    rand_ready = 1'b0;
    checkOutput("t3_handshakes", 32'(hs), 32'd1088);
    checkOutput("t3_last_drain", 32'(log_q[log_q.size() - 1]),
                32'(cmd_t'({3'd3, 3'd7, 3'd7, 3'd0, 1'b0, 1'b1})));
    checkOutput("t3_tiles_done", 32'(tiles_done), 32'd64);

    // Rejected jobs: zero and oversized counts
    applyStimulus(1, 1, 0, 1'b0, 1'b0);
    checkOutput("t4_err_zero", 32'({job_err, cmd_valid, job_busy}), 32'b100);
    @(negedge clk);
    checkOutput("t4_err_zero_after", 32'({job_err, cmd_valid, job_busy}), 32'b000);
    applyStimulus(1, 1, 9, 1'b0, 1'b0);
    checkOutput("t4_err_nine", 32'({job_err, cmd_valid, job_busy}), 32'b100);
    @(negedge clk);
    checkIdle("t4_after_err", 8'd64);

    // Spurious cmd_done during ISSUE plus a start while busy
    done_delay = 2;
    spurious = 1'b1;
    runJob(2, 3, 2, 1'b0, 1'b1, hs);
    spurious = 1'b0;
    checkOutput("t5_handshakes", 32'(hs), 32'd28);
    checkOutput("t5_tiles_done", 32'(tiles_done), 32'd4);

    // Reset while waiting on the 5th command
    done_delay = 3;
    log_q.delete();
    h0 = hs_count;
    applyStimulus(2, 3, 2, 1'b1, 1'b1);
    for (i = 0; i < 200 && hs_count < h0 + 5; i++) @(negedge clk);
    if (hs_count < h0 + 5) checkOutput("t6_wait_timeout", 32'd0, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkIdle("t6_after_reset", '0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    runJob(1, 2, 1, 1'b0, 1'b0, hs);
    checkOutput("t6_handshakes", 32'(hs), 32'd5);
    checkOutput("t6_first_cmd", 32'(log_q[0]), 32'(cmd_t'({3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0})));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
